dso_trigger_ctrl: RTL
=====================

Name: dso_trigger_ctrl

Overview:
- Trigger sequencer placed between the ADC sample stream and the acquisition driver's `trigger_req` input.
- Detects level crossings on the sampled ADC data and applies a post-capture holdoff.
- Implements the NORMAL, AUTO, IMMEDIATE and SINGLE trigger modes.
- Drives `trigger_req` only while the driver reports it is waiting for a trigger.

Parameters:
- DATA_W, 8, ADC sample width (unsigned).
- AUTO_W, 20, width of the auto-timeout sample counter.
- HOLD_W, 16, width of the holdoff sample counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- mode  in  2  0=NORMAL, 1=AUTO, 2=IMMEDIATE, 3=SINGLE; sampled only on entry to ARMED.
- edge_fall  in  1  0=rising crossing, 1=falling crossing; sampled on entry to ARMED.
- trig_level  in  DATA_W  crossing threshold.
- auto_timeout  in  AUTO_W  AUTO-mode timeout, in sample strobes.
- holdoff  in  HOLD_W  sample strobes to ignore after a capture completes.
- arm  in  1  single-cycle pulse; re-arms SINGLE mode from STOPPED.
- adc_data  in  DATA_W  current ADC sample.
- sample_stb  in  1  high when `adc_data` is a new sample (driver memory write strobe).
- drv_waiting  in  1  driver is in its wait-for-trigger state.
- drv_triggered  in  1  driver is filling the post-trigger half-buffer.
- drv_valid  in  1  driver's buffer-ready flag.
- trigger_req  out  1  trigger request to the driver.
- auto_fired  out  1  last trigger was forced by timeout.
- stopped  out  1  SINGLE capture done; waiting for `arm`.
- ctrl_state  out  3  state encoding, for the status register.

Behaviour:
- Reset:
  - state=IDLE; `trigger_req`, `auto_fired`, `stopped` = 0.
  - All counters = 0; previous-sample register = 0; prev_valid = 0.
- Crossing detect, evaluated only when `sample_stb`=1:
  - rising: prev < trig_level AND adc_data >= trig_level.
  - falling: prev >= trig_level AND adc_data < trig_level.
  - prev is updated on every `sample_stb` in every state.
  - prev_valid is cleared on entry to SEEK; the first strobe in SEEK only loads prev and never detects.
  - All comparisons are unsigned, full DATA_W.
- States (encoding in parentheses):
  - IDLE(0): next cycle -> ARMED.
  - ARMED(1): latch mode/edge_fall. Wait for `drv_waiting`=1. Then IMMEDIATE -> FIRE, else -> SEEK. Clear the auto counter.
  - SEEK(2): on each `sample_stb`, increment the auto counter.
    - Crossing -> FIRE, and `auto_fired`<=0.
    - Else if AUTO mode and the counter reaches `auto_timeout` -> FIRE, and `auto_fired`<=1.
    - If both happen on the same strobe, the crossing wins (`auto_fired`=0).
    - `auto_timeout`=0 in AUTO fires on the first strobe in SEEK.
  - FIRE(3): `trigger_req`=1 (registered; it rises the cycle after FIRE is entered). Hold until `drv_triggered`=1, then drop `trigger_req` and go to FILL.
  - FILL(4): wait for `drv_valid`=1.
    - SINGLE -> STOPPED.
    - Else -> HOLDOFF, with the holdoff counter cleared.
  - HOLDOFF(5): count `sample_stb`. When count == `holdoff` -> ARMED. `holdoff`=0 gives a single-cycle pass-through.
  - STOPPED(6): `stopped`=1. An `arm` pulse -> HOLDOFF and clears `stopped`. `arm` in any other state is ignored.
- The auto counter saturates at all-ones and does not wrap.
- `trigger_req` is never asserted unless the state is FIRE.
- If `drv_waiting` drops while in SEEK (e.g. the driver was reset externally): go to ARMED, no fire.
- `rst` mid-operation: return to reset values next cycle; any asserted `trigger_req` drops immediately.
- `mode` changes outside ARMED take effect at the next ARMED entry.

Optional Feature:
- Macro: DSO_TRIG_HYST_EN.
- When defined:
  - Adds an input `trig_hyst` [DATA_W] and a qualifier flag `hyst_ok` that gates crossing detection.
  - `hyst_ok` is cleared on entry to SEEK.
  - Rising mode: `hyst_ok` is set once a sample <= trig_level - trig_hyst is seen. Falling mode: once a sample >= trig_level + trig_hyst is seen.
  - Threshold arithmetic saturates at 0 / all-ones.
  - A crossing fires only when `hyst_ok`=1.
- When undefined: the port is absent and crossing detection is as described above.

Test Plan:
- NORMAL, rising, level=0x80, ramp 0x70..0x90 step 1 on every strobe, `drv_waiting`=1:
  - FIRE is entered on the strobe where the sample is 0x80.
  - `trigger_req` goes high the next cycle and stays high until `drv_triggered`.
  - `auto_fired`=0.
- AUTO, `auto_timeout`=16, flat data 0x10: `trigger_req` rises after the 16th strobe in SEEK; `auto_fired`=1.
- IMMEDIATE: `trigger_req` rises 2 cycles after `drv_waiting` goes high; no strobes are required.
- SINGLE, falling edge:
  - After the first capture and `drv_valid`, `stopped`=1.
  - Further crossings produce no `trigger_req`.
  - An `arm` pulse followed by `holdoff`=4 strobes returns the block to ARMED.
- `rst` asserted while in FIRE: `trigger_req`=0 and `ctrl_state`=0 the next cycle.
- With DSO_TRIG_HYST_EN, level=0x80, hyst=0x10:
  - Noise 0x7C..0x84 produces no fire.
  - A dip to 0x70 followed by a rise through 0x80 fires.

Source files
------------

// File: rtl/dso_trigger_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dso_trigger_ctrl
// Description : Oscilloscope trigger sequencer. Detects level crossings on
//               the ADC sample stream, applies holdoff, and implements the
//               NORMAL / AUTO / IMMEDIATE / SINGLE modes.
//               Optional hysteresis qualifier: define DSO_TRIG_HYST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dso_trigger_ctrl #(
    parameter int DATA_W = 8,
    parameter int AUTO_W = 20,
    parameter int HOLD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              edge_fall,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [AUTO_W-1:0] auto_timeout,
    input  logic [HOLD_W-1:0] holdoff,
    input  logic              arm,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              sample_stb,
    input  logic              drv_waiting,
    input  logic              drv_triggered,
    input  logic              drv_valid,
`ifdef DSO_TRIG_HYST_EN
    input  logic [DATA_W-1:0] trig_hyst,
`endif
    output logic              trigger_req,
    output logic              auto_fired,
    output logic              stopped,
    output logic [2:0]        ctrl_state
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_armed   = 3'd1;
    localparam logic [2:0] c_st_seek    = 3'd2;
    localparam logic [2:0] c_st_fire    = 3'd3;
    localparam logic [2:0] c_st_fill    = 3'd4;
    localparam logic [2:0] c_st_holdoff = 3'd5;
    localparam logic [2:0] c_st_stopped = 3'd6;

    localparam logic [1:0] c_mode_normal = 2'd0;
    localparam logic [1:0] c_mode_auto   = 2'd1;
    localparam logic [1:0] c_mode_imm    = 2'd2;
    localparam logic [1:0] c_mode_single = 2'd3;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [1:0]        r_mode;
    logic              r_edge_fall;
    logic [DATA_W-1:0] r_prev;
    logic              r_prev_valid;
    logic [AUTO_W-1:0] r_auto_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_trigger_req;
    logic              r_auto_fired;
    logic              r_stopped;

    logic              w_rise_x;
    logic              w_fall_x;
    logic              w_hyst_gate;
    logic              w_cross;
    logic [AUTO_W-1:0] w_auto_inc;
    logic              w_timeout;
    logic              w_enter_armed;
    logic              w_enter_seek;
    logic              w_enter_holdoff;

    assign w_rise_x = (r_prev < trig_level) && (adc_data >= trig_level);
    assign w_fall_x = (r_prev >= trig_level) && (adc_data < trig_level);

`ifdef DSO_TRIG_HYST_EN
    logic [DATA_W:0]   w_hi_sum;
    logic [DATA_W-1:0] w_hyst_hi;
    logic [DATA_W-1:0] w_hyst_lo;
    logic              w_hyst_seen;
    logic              r_hyst_ok;

    // Re-arm thresholds clamp at the ends of the sample range.
    assign w_hi_sum    = {1'b0, trig_level} + {1'b0, trig_hyst};
    assign w_hyst_hi   = w_hi_sum[DATA_W] ? '1 : w_hi_sum[DATA_W-1:0];
    assign w_hyst_lo   = (trig_level >= trig_hyst) ? (trig_level - trig_hyst) : '0;
    assign w_hyst_seen = sample_stb &&
                         (r_edge_fall ? (adc_data >= w_hyst_hi) : (adc_data <= w_hyst_lo));
    assign w_hyst_gate = r_hyst_ok;
`else
    assign w_hyst_gate = 1'b1;
`endif

    assign w_cross    = sample_stb && r_prev_valid && w_hyst_gate &&
                        (r_edge_fall ? w_fall_x : w_rise_x);
    assign w_auto_inc = (&r_auto_cnt) ? r_auto_cnt : (r_auto_cnt + AUTO_W'(1));
    assign w_timeout  = sample_stb && (r_mode == c_mode_auto) && (w_auto_inc >= auto_timeout);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:    w_next_state = c_st_armed;
            c_st_armed:   if (drv_waiting)
                              w_next_state = (r_mode == c_mode_imm) ? c_st_fire : c_st_seek;
            c_st_seek:    if (!drv_waiting)
                              w_next_state = c_st_armed;
                          else if (w_cross || w_timeout)
                              w_next_state = c_st_fire;
            c_st_fire:    if (drv_triggered)
                              w_next_state = c_st_fill;
            c_st_fill:    if (drv_valid)
                              w_next_state = (r_mode == c_mode_single) ? c_st_stopped : c_st_holdoff;
            c_st_holdoff: if (r_hold_cnt >= holdoff)
                              w_next_state = c_st_armed;
            c_st_stopped: if (arm)
                              w_next_state = c_st_holdoff;
            default:      w_next_state = c_st_idle;
        endcase
    end

    assign w_enter_armed   = (w_next_state == c_st_armed)   && (r_state != c_st_armed);
    assign w_enter_seek    = (w_next_state == c_st_seek)    && (r_state != c_st_seek);
    assign w_enter_holdoff = (w_next_state == c_st_holdoff) && (r_state != c_st_holdoff);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_mode        <= c_mode_normal;
            r_edge_fall   <= 1'b0;
            r_prev        <= '0;
            r_prev_valid  <= 1'b0;
            r_auto_cnt    <= '0;
            r_hold_cnt    <= '0;
            r_trigger_req <= 1'b0;
            r_auto_fired  <= 1'b0;
            r_stopped     <= 1'b0;
        end else begin
            r_state <= w_next_state;

            // Entry clear wins over a coincident strobe so SEEK always starts fresh.
            if (sample_stb) begin
                r_prev       <= adc_data;
                r_prev_valid <= 1'b1;
            end
            if (w_enter_seek)
                r_prev_valid <= 1'b0;

            if (w_enter_armed) begin
                r_mode      <= mode;
                r_edge_fall <= edge_fall;
            end

            if (r_state == c_st_armed)
                r_auto_cnt <= '0;
            else if ((r_state == c_st_seek) && sample_stb)
                r_auto_cnt <= w_auto_inc;

            if ((r_state == c_st_seek) && (w_next_state == c_st_fire))
                r_auto_fired <= !w_cross;
            else if ((r_state == c_st_armed) && (w_next_state == c_st_fire))
                r_auto_fired <= 1'b0;

            if (w_enter_holdoff)
                r_hold_cnt <= '0;
            else if ((r_state == c_st_holdoff) && sample_stb)
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);

            // Registered from the current state, so the request lags FIRE entry by one cycle.
            r_trigger_req <= (r_state == c_st_fire) && !drv_triggered;
            r_stopped     <= (w_next_state == c_st_stopped);
        end
    end

`ifdef DSO_TRIG_HYST_EN
    always_ff @(posedge clk) begin
        if (rst)
            r_hyst_ok <= 1'b0;
        else if (w_enter_seek)
            r_hyst_ok <= 1'b0;
        else if (w_hyst_seen)
            r_hyst_ok <= 1'b1;
    end
`endif

    assign trigger_req = r_trigger_req;
    assign auto_fired  = r_auto_fired;
    assign stopped     = r_stopped;
    assign ctrl_state  = r_state;

endmodule
`default_nettype wire
